id_ex_stage: RTL and testbench

//  Downstream neighbour of the IF/ID front end: consumes the decoded ID-stage fields and

---
 rtl/id_ex_stage_pkg.sv | 30 +++
 rtl/id_ex_stage_if.sv | 59 +++++
 rtl/id_ex_stage_hazard_detection_unit.sv | 24 ++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 tb/tb_id_ex_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcodes, ALU op classes and control word for the ID/EX stage
package id_ex_stage_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD    = 2'b00,
        ALUOP_BRANCH = 2'b01,
        ALUOP_R      = 2'b10,
        ALUOP_I      = 2'b11
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    branch;
        alu_op_t alu_op;
    } ctrl_word_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side inputs, EX-side outputs and front-end stall lines of the ID/EX stage
interface id_ex_stage_if
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);

    logic                  PCSrc;
    logic [XLEN-1:0]       PC_ID;
    logic [XLEN-1:0]       IMM_ID;
    logic [XLEN-1:0]       REG_DATA1_ID;
    logic [XLEN-1:0]       REG_DATA2_ID;
    logic [2:0]            FUNCT3_ID;
    logic [6:0]            FUNCT7_ID;
    logic [6:0]            OPCODE_ID;
    logic [REG_ADDR_W-1:0] RD_ID;
    logic [REG_ADDR_W-1:0] RS1_ID;
    logic [REG_ADDR_W-1:0] RS2_ID;

    logic                  PC_write;
    logic                  IF_IDwrite;

    logic [XLEN-1:0]       PC_EX;
    logic [XLEN-1:0]       IMM_EX;
    logic [XLEN-1:0]       REG_DATA1_EX;
    logic [XLEN-1:0]       REG_DATA2_EX;
    logic [2:0]            FUNCT3_EX;
    logic [6:0]            FUNCT7_EX;
    logic [REG_ADDR_W-1:0] RD_EX;
    logic [REG_ADDR_W-1:0] RS1_EX;
    logic [REG_ADDR_W-1:0] RS2_EX;
    logic                  RegWrite_EX;
    logic                  MemtoReg_EX;
    logic                  MemRead_EX;
    logic                  MemWrite_EX;
    logic                  ALUSrc_EX;
    logic                  Branch_EX;
    logic [1:0]            ALUOp_EX;

    modport master (
        output PCSrc, PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID,
               FUNCT3_ID, FUNCT7_ID, OPCODE_ID, RD_ID, RS1_ID, RS2_ID,
        input  PC_write, IF_IDwrite,
               PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX,
               RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX,
               MemWrite_EX, ALUSrc_EX, Branch_EX, ALUOp_EX
    );

    modport slave (
        input  PCSrc, PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID,
               FUNCT3_ID, FUNCT7_ID, OPCODE_ID, RD_ID, RS1_ID, RS2_ID,
        output PC_write, IF_IDwrite,
               PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX, FUNCT3_EX, FUNCT7_EX,
               RD_EX, RS1_EX, RS2_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX,
               MemWrite_EX, ALUSrc_EX, Branch_EX, ALUOp_EX
    );

endinterface

// File: rtl/id_ex_stage_hazard_detection_unit.sv
// rtl/id_ex_stage_hazard_detection_unit.sv - combinational load-use hazard detector
module hazard_detection_unit #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  MemRead_EX,
    input  logic [REG_ADDR_W-1:0] RD_EX,
    input  logic [REG_ADDR_W-1:0] RS1_ID,
    input  logic [REG_ADDR_W-1:0] RS2_ID,
    input  logic                  uses_rs2,
    input  logic                  PCSrc,
    output logic                  stall
);

    logic hazard;

    // A load in EX whose destination feeds the ID instruction forces one bubble;
    // x0 is never a real dependency, and a taken branch makes the ID instruction wrong-path.
    always_comb begin
        hazard = MemRead_EX && (RD_EX != '0) &&
                 ((RD_EX == RS1_ID) || (uses_rs2 && (RD_EX == RS2_ID)));
        stall  = hazard && !PCSrc;
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with control decode, bubble insertion and flush
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    ctrl_word_t            ctrl_id;
    ctrl_word_t            ctrl_next;
    ctrl_word_t            ctrl_ex;
    logic                  uses_rs2;
    logic                  stall;

    logic [XLEN-1:0]       pc_ex;
    logic [XLEN-1:0]       imm_ex;
    logic [XLEN-1:0]       data1_ex;
    logic [XLEN-1:0]       data2_ex;
    logic [2:0]            funct3_ex;
    logic [6:0]            funct7_ex;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic [REG_ADDR_W-1:0] rs1_ex;
    logic [REG_ADDR_W-1:0] rs2_ex;

    // Main control word and rs2-usage from the ID opcode; unknown opcodes decode as NOP
    always_comb begin
        ctrl_id  = '0;
        uses_rs2 = 1'b0;
        case (bus.OPCODE_ID)
            OP_R: begin
                ctrl_id.reg_write = 1'b1;
                ctrl_id.alu_op    = ALUOP_R;
                uses_rs2          = 1'b1;
            end
            OP_I: begin
                ctrl_id.reg_write = 1'b1;
                ctrl_id.alu_src   = 1'b1;
                ctrl_id.alu_op    = ALUOP_I;
            end
            OP_LOAD: begin
                ctrl_id.reg_write  = 1'b1;
                ctrl_id.mem_to_reg = 1'b1;
                ctrl_id.mem_read   = 1'b1;
                ctrl_id.alu_src    = 1'b1;
                ctrl_id.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl_id.mem_write = 1'b1;
                ctrl_id.alu_src   = 1'b1;
                ctrl_id.alu_op    = ALUOP_ADD;
                uses_rs2          = 1'b1;
            end
            OP_BRANCH: begin
                ctrl_id.branch = 1'b1;
                ctrl_id.alu_op = ALUOP_BRANCH;
                uses_rs2       = 1'b1;
            end
            default: begin
                ctrl_id  = '0;
                uses_rs2 = 1'b0;
            end
        endcase
    end

    hazard_detection_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detection_unit (
        .MemRead_EX (ctrl_ex.mem_read),
        .RD_EX      (rd_ex),
        .RS1_ID     (bus.RS1_ID),
        .RS2_ID     (bus.RS2_ID),
        .uses_rs2   (uses_rs2),
        .PCSrc      (bus.PCSrc),
        .stall      (stall)
    );

    // Bubble on a stall and squash on a taken branch both load an all-zero control word
    always_comb begin
        ctrl_next = ctrl_id;
        if (stall || bus.PCSrc) begin
            ctrl_next = '0;
        end
    end

    // ID/EX register: control word plus data/index fields, captured every edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_ex   <= '0;
            pc_ex     <= '0;
            imm_ex    <= '0;
            data1_ex  <= '0;
            data2_ex  <= '0;
            funct3_ex <= '0;
            funct7_ex <= '0;
            rd_ex     <= '0;
            rs1_ex    <= '0;
            rs2_ex    <= '0;
        end else begin
            ctrl_ex   <= ctrl_next;
            pc_ex     <= bus.PC_ID;
            imm_ex    <= bus.IMM_ID;
            data1_ex  <= bus.REG_DATA1_ID;
            data2_ex  <= bus.REG_DATA2_ID;
            funct3_ex <= bus.FUNCT3_ID;
            funct7_ex <= bus.FUNCT7_ID;
            rd_ex     <= bus.RD_ID;
            rs1_ex    <= bus.RS1_ID;
            rs2_ex    <= bus.RS2_ID;
        end
    end

    // Front end holds PC and IF/ID for exactly the bubble cycle
    always_comb begin
        bus.PC_write   = !stall;
        bus.IF_IDwrite = !stall;
    end

    // Registered fields out to the EX stage
    always_comb begin
        bus.PC_EX        = pc_ex;
        bus.IMM_EX       = imm_ex;
        bus.REG_DATA1_EX = data1_ex;
        bus.REG_DATA2_EX = data2_ex;
        bus.FUNCT3_EX    = funct3_ex;
        bus.FUNCT7_EX    = funct7_ex;
        bus.RD_EX        = rd_ex;
        bus.RS1_EX       = rs1_ex;
        bus.RS2_EX       = rs2_ex;
        bus.RegWrite_EX  = ctrl_ex.reg_write;
        bus.MemtoReg_EX  = ctrl_ex.mem_to_reg;
        bus.MemRead_EX   = ctrl_ex.mem_read;
        bus.MemWrite_EX  = ctrl_ex.mem_write;
        bus.ALUSrc_EX    = ctrl_ex.alu_src;
        bus.Branch_EX    = ctrl_ex.branch;
        bus.ALUOp_EX     = ctrl_ex.alu_op;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for the ID/EX stage
module tb_id_ex_stage;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic       m_memread = 1'b0;
    logic [4:0] m_rd      = 5'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, ALUOp[1:0]}
    function automatic logic [7:0] ref_ctrl(input logic [6:0] op);
        case (op)
            7'b0110011: return 8'b100000_10;
            7'b0010011: return 8'b100010_11;
            7'b0000011: return 8'b111010_00;
            7'b0100011: return 8'b000110_00;
            7'b1100011: return 8'b000001_01;
            default:    return 8'b000000_00;
        endcase
    endfunction

    function automatic logic ref_uses_rs2(input logic [6:0] op);
        return (op == 7'b0110011) || (op == 7'b0100011) || (op == 7'b1100011);
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {bus.RegWrite_EX, bus.MemtoReg_EX, bus.MemRead_EX, bus.MemWrite_EX,
                bus.ALUSrc_EX, bus.Branch_EX, bus.ALUOp_EX};
    endfunction

    task automatic check_zero(input string tag);
        check_val({tag, "_ctrl"}, {24'd0, dut_ctrl()}, 32'd0);
        check_val({tag, "_pc"}, bus.PC_EX, 32'd0);
        check_val({tag, "_data"}, bus.REG_DATA1_EX | bus.REG_DATA2_EX | bus.IMM_EX, 32'd0);
        check_val({tag, "_idx"}, {17'd0, bus.RD_EX, bus.RS1_EX, bus.RS2_EX}, 32'd0);
        check_val({tag, "_pcw"}, {31'd0, bus.PC_write}, 32'd1);
        check_val({tag, "_ifw"}, {31'd0, bus.IF_IDwrite}, 32'd1);
    endtask

    task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic pcsrc, input logic [31:0] d1);
        bus.OPCODE_ID    = op;
        bus.RD_ID        = rd;
        bus.RS1_ID       = rs1;
        bus.RS2_ID       = rs2;
        bus.PCSrc        = pcsrc;
        bus.REG_DATA1_ID = d1;
        bus.REG_DATA2_ID = $urandom;
        bus.PC_ID        = $urandom;
        bus.IMM_ID       = $urandom;
        bus.FUNCT3_ID    = 3'($urandom);
        bus.FUNCT7_ID    = 7'($urandom);
    endtask

    // One clock: drive ID, check stall lines, push expectation, then pop and compare after the edge
    task automatic cycle(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic pcsrc, input logic [31:0] d1,
                         output logic stalled);
        exp_t e;
        logic hz;
        @(negedge clk);
        drive(op, rd, rs1, rs2, pcsrc, d1);
        hz = m_memread && (m_rd != 5'd0) &&
             ((m_rd == rs1) || (ref_uses_rs2(op) && (m_rd == rs2)));
        stalled = hz && !pcsrc;
        #1;
        check_val("PC_write", {31'd0, bus.PC_write}, {31'd0, !stalled});
        check_val("IF_IDwrite", {31'd0, bus.IF_IDwrite}, {31'd0, !stalled});
        e.ctrl = (stalled || pcsrc) ? 8'd0 : ref_ctrl(op);
        e.pc   = bus.PC_ID;
        e.imm  = bus.IMM_ID;
        e.d1   = d1;
        e.d2   = bus.REG_DATA2_ID;
        e.f3   = bus.FUNCT3_ID;
        e.f7   = bus.FUNCT7_ID;
        e.rd   = rd;
        e.rs1  = rs1;
        e.rs2  = rs2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_val("ctrl", {24'd0, dut_ctrl()}, {24'd0, e.ctrl});
            check_val("PC_EX", bus.PC_EX, e.pc);
            check_val("IMM_EX", bus.IMM_EX, e.imm);
            check_val("REG_DATA1_EX", bus.REG_DATA1_EX, e.d1);
            check_val("REG_DATA2_EX", bus.REG_DATA2_EX, e.d2);
            check_val("funct", {22'd0, bus.FUNCT3_EX, bus.FUNCT7_EX}, {22'd0, e.f3, e.f7});
            check_val("regs", {17'd0, bus.RD_EX, bus.RS1_EX, bus.RS2_EX},
                      {17'd0, e.rd, e.rs1, e.rs2});
            m_memread = e.ctrl[5];
            m_rd      = e.rd;
        end
    endtask

    // Present an instruction, re-presenting it while the front end is held
    task automatic issue(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic pcsrc, input logic [31:0] d1,
                         output int nstall);
        logic st;
        bit   done;
        nstall = 0;
        done   = 1'b0;
        for (int i = 0; i < 4 && !done; i++) begin
            cycle(op, rd, rs1, rs2, pcsrc, d1, st);
            if (st) nstall++;
            else    done = 1'b1;
        end
        if (!done) check_val("stall_bound", 32'd0, 32'd1);
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;

    initial begin
        int n;
        int nsum;
        logic [6:0] ops [6];
        ops[0] = R; ops[1] = I; ops[2] = LD; ops[3] = ST; ops[4] = BR; ops[5] = JL;

        drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0);
        #1;
        check_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;

        // R-type basic
        issue(R, 5'd3, 5'd1, 5'd2, 1'b0, 32'd5, n);
        check_val("r_no_stall", n, 0);

        // Async reset mid-cycle clears the EX state at once
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_zero("reset_mid");
        @(negedge clk);
        reset     = 1'b0;
        m_memread = 1'b0;
        m_rd      = 5'd0;

        // Load-use stall
        issue(LD, 5'd5, 5'd1, 5'd0, 1'b0, 32'h11, n);
        issue(R, 5'd6, 5'd5, 5'd4, 1'b0, 32'h22, n);
        check_val("lu_stalls", n, 1);

        // x0 destination and I-type rs2 field never stall
        issue(LD, 5'd0, 5'd1, 5'd0, 1'b0, 32'h33, n);
        issue(R, 5'd4, 5'd0, 5'd0, 1'b0, 32'h44, n);
        check_val("x0_no_stall", n, 0);
        issue(LD, 5'd7, 5'd1, 5'd0, 1'b0, 32'h55, n);
        issue(I, 5'd8, 5'd1, 5'd7, 1'b0, 32'h66, n);
        check_val("i_rs2_no_stall", n, 0);

        // Flush of a store; flush overrides a pending hazard
        issue(ST, 5'd0, 5'd1, 5'd2, 1'b1, 32'h77, n);
        issue(LD, 5'd9, 5'd1, 5'd0, 1'b0, 32'h88, n);
        issue(R, 5'd10, 5'd9, 5'd9, 1'b1, 32'h99, n);
        check_val("flush_no_stall", n, 0);

        // Back-to-back dependent loads
        issue(LD, 5'd2, 5'd1, 5'd0, 1'b0, 32'ha0, n);
        nsum = 0;
        issue(LD, 5'd3, 5'd2, 5'd0, 1'b0, 32'ha1, n);
        nsum += n;
        issue(R, 5'd11, 5'd3, 5'd1, 1'b0, 32'ha2, n);
        nsum += n;
        check_val("b2b_stalls", nsum, 2);

        // Store rs2 dependency, branch and NOP decode
        issue(LD, 5'd12, 5'd1, 5'd0, 1'b0, 32'hb0, n);
        issue(ST, 5'd0, 5'd1, 5'd12, 1'b0, 32'hb1, n);
        check_val("st_rs2_stall", n, 1);
        issue(BR, 5'd0, 5'd4, 5'd5, 1'b0, 32'hb2, n);
        issue(JL, 5'd1, 5'd0, 5'd0, 1'b0, 32'hb3, n);

        // Reset during the stall cycle releases the front end
        issue(LD, 5'd5, 5'd1, 5'd0, 1'b0, 32'hc0, n);
        @(negedge clk);
        drive(R, 5'd6, 5'd5, 5'd0, 1'b0, 32'hc1);
        #1;
        check_val("stall_seen", {31'd0, bus.PC_write}, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_stall");
        @(negedge clk);
        reset     = 1'b0;
        m_memread = 1'b0;
        m_rd      = 5'd0;
        issue(R, 5'd6, 5'd5, 5'd0, 1'b0, 32'hc2, n);
        check_val("after_reset_no_stall", n, 0);

        // Mixed random traffic
        for (int k = 0; k < 40; k++) begin
            issue(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), $urandom, n);
        end

        check_val("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
